// File: rtl/force_release_sched.sv
// -----------------------------------------------------------------------------
// force_release_sched
//
// Sequences force/release operations onto a WIDTH-bit packed port on behalf
// of NREQ requesters. A round-robin arbiter picks one requester in IDLE; the
// winner's masked bits are forced to its value for hold+1 cycles (or until
// abort). A single RELEASE cycle then pulses release_p on the masked bits and
// pulses done to the owner. At least one IDLE cycle separates owners.
//
// Optional feature (macro FORCE_RELEASE_SCHED_ERR_EN):
//   Adds a sticky err flag with an err_clr input. err is set when a zero-mask
//   request is accepted or when abort is seen in IDLE. A set in the same
//   cycle as err_clr wins over the clear.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request valid                  [NREQ]
//   req_ready    per-requester accept, one-hot or zero, IDLE only [NREQ]
//   req_mask     bits to force, requester i at [i*WIDTH +: WIDTH]
//   req_value    force values, same packing as req_mask
//   req_hold     hold count, requester i at [i*HOLD_W +: HOLD_W]
//   abort        end the current FORCE early
//   force_en     per-bit force enable                         [WIDTH]
//   force_val    per-bit force value (value & mask)           [WIDTH]
//   release_p    per-bit one-cycle release pulse              [WIDTH]
//   grant        one-hot current owner, zero in IDLE          [NREQ]
//   busy         high in FORCE or RELEASE
//   done         one-cycle completion pulse to the owner      [NREQ]
//   err_clr, err (only with FORCE_RELEASE_SCHED_ERR_EN)
// -----------------------------------------------------------------------------
module force_release_sched #(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    parameter int HOLD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_mask,
    input  logic [NREQ*WIDTH-1:0]    req_value,
    input  logic [NREQ*HOLD_W-1:0]   req_hold,
    input  logic                     abort,
    output logic [WIDTH-1:0]         force_en,
    output logic [WIDTH-1:0]         force_val,
    output logic [WIDTH-1:0]         release_p,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic [NREQ-1:0]          done
`ifdef FORCE_RELEASE_SCHED_ERR_EN
    ,
    input  logic                     err_clr,
    output logic                     err
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORCE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [PTR_W-1:0]    rr_q,        rr_d;
    logic [HOLD_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]    mask_q,      mask_d;
    logic [WIDTH-1:0]    value_q,     value_d;
    logic [NREQ-1:0]     grant_q,     grant_d;
    logic [WIDTH-1:0]    force_en_q,  force_en_d;
    logic [WIDTH-1:0]    force_val_q, force_val_d;
    logic [WIDTH-1:0]    release_q,   release_d;
    logic [NREQ-1:0]     done_q,      done_d;
    logic                busy_q,      busy_d;

    // Arbitration results
    logic [2*NREQ-1:0]   rot;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    win_nxt;
    int                  pos;
    logic [WIDTH-1:0]    cap_mask;
    logic [WIDTH-1:0]    cap_value;
    logic [HOLD_W-1:0]   cap_hold;
    logic                accept;

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin: rotate the valid vector so rr_q sits at bit 0, take the
    // lowest set bit, then map the offset back to a requester index.
    always_comb begin
        rot       = {req_valid, req_valid} >> rr_q;
        win_found = 1'b0;
        win_idx   = '0;
        win_nxt   = '0;
        pos       = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && rot[k]) begin
                win_found = 1'b1;
                pos       = int'(rr_q) + k;
                if (pos >= NREQ) pos = pos - NREQ;
                win_idx   = PTR_W'(pos);
                win_nxt   = PTR_W'((pos + 1) % NREQ);
            end
        end
    end

    // Mux out the winner's request fields.
    always_comb begin
        cap_mask  = '0;
        cap_value = '0;
        cap_hold  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                cap_mask  = req_mask[i*WIDTH +: WIDTH];
                cap_value = req_value[i*WIDTH +: WIDTH];
                cap_hold  = req_hold[i*HOLD_W +: HOLD_W];
            end
        end
    end

    // Ready is combinational from the arbiter; gated by reset so every output
    // reads zero while rst_n is low.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && win_found) begin
            req_ready = onehot(win_idx);
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        value_d     = value_q;
        grant_d     = grant_q;
        force_en_d  = '0;
        force_val_d = '0;
        release_d   = '0;
        done_d      = '0;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d     = ST_FORCE;
                    rr_d        = win_nxt;
                    cnt_d       = cap_hold;
                    mask_d      = cap_mask;
                    value_d     = cap_value & cap_mask;
                    grant_d     = onehot(win_idx);
                    force_en_d  = cap_mask;
                    force_val_d = cap_value & cap_mask;
                    busy_d      = 1'b1;
                end
            end
            ST_FORCE: begin
                busy_d = 1'b1;
                // abort overrides whatever count remains
                if (abort || (cnt_q == '0)) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = '0;
                    release_d = mask_q;
                    done_d    = grant_q;
                end else begin
                    cnt_d       = cnt_q - 1'b1;
                    force_en_d  = mask_q;
                    force_val_d = value_q;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            grant_q     <= '0;
            force_en_q  <= '0;
            force_val_q <= '0;
            release_q   <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            grant_q     <= grant_d;
            force_en_q  <= force_en_d;
            force_val_q <= force_val_d;
            release_q   <= release_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign force_en  = force_en_q;
    assign force_val = force_val_q;
    assign release_p = release_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef FORCE_RELEASE_SCHED_ERR_EN
    logic err_q, err_d;
    logic err_set;

    assign err_set = (state_q == ST_IDLE) &&
                     ((accept && (cap_mask == '0)) || abort);

    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_force_release_sched.sv
module tb_force_release_sched;

    localparam int WIDTH  = 8;
    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTH-1:0]  req_mask;
    logic [NREQ*WIDTH-1:0]  req_value;
    logic [NREQ*HOLD_W-1:0] req_hold;
    logic                   abort;
    logic [WIDTH-1:0]       force_en;
    logic [WIDTH-1:0]       force_val;
    logic [WIDTH-1:0]       release_p;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic [NREQ-1:0]        done;
`ifdef FORCE_RELEASE_SCHED_ERR_EN
    logic                   err_clr;
    logic                   err;
`endif

    force_release_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .HOLD_W(HOLD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mask  (req_mask),
        .req_value (req_value),
        .req_hold  (req_hold),
        .abort     (abort),
        .force_en  (force_en),
        .force_val (force_val),
        .release_p (release_p),
        .grant     (grant),
        .busy      (busy),
        .done      (done)
`ifdef FORCE_RELEASE_SCHED_ERR_EN
        ,
        .err_clr   (err_clr),
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Same mask/value/hold presented by every requester
    task automatic set_all(input logic [7:0] m, input logic [7:0] v, input logic [7:0] h);
        req_mask  = {NREQ{m}};
        req_value = {NREQ{v}};
        req_hold  = {NREQ{h}};
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); #1;
            if (busy === 1'b1) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [7:0] mask;
        logic [7:0] value;
        logic [7:0] hold;
        logic       abrt;
        logic [3:0] rdy;
        logic [7:0] fen;
        logic [7:0] fval;
        logic [7:0] rel;
        logic [3:0] dn;
        logic [3:0] gnt;
        logic       bsy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] valid, input logic [7:0] m, input logic [7:0] v,
                                input logic [7:0] h, input logic ab, input logic [3:0] rdy,
                                input logic [7:0] fen, input logic [7:0] fval, input logic [7:0] rel,
                                input logic [3:0] dn, input logic [3:0] gnt, input logic bsy);
        vec_t r;
        r.valid = valid; r.mask = m; r.value = v; r.hold = h; r.abrt = ab;
        r.rdy = rdy; r.fen = fen; r.fval = fval; r.rel = rel; r.dn = dn; r.gnt = gnt; r.bsy = bsy;
        return r;
    endfunction

    vec_t tbl [0:20];

    initial begin
        bit ok;
        int ngr, gap, n, rel_seen;
        logic [3:0] prev_g;
        logic [3:0] exp_own [0:4];

        //           valid   mask   value  hold  ab  rdy     fen    fval   rel    done    grant   busy
        tbl[0]  = mk(4'b0001, 8'h0F, 8'h05, 8'd3, 0, 4'b0001, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        tbl[1]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h0F, 8'h05, 8'h00, 4'b0000, 4'b0001, 1);
        tbl[2]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h0F, 8'h05, 8'h00, 4'b0000, 4'b0001, 1);
        tbl[3]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h0F, 8'h05, 8'h00, 4'b0000, 4'b0001, 1);
        tbl[4]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h0F, 8'h05, 8'h00, 4'b0000, 4'b0001, 1);
        tbl[5]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h00, 8'h00, 8'h0F, 4'b0001, 4'b0001, 1);
        tbl[6]  = mk(4'b0000, 8'h0F, 8'h05, 8'd3, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        // abort in IDLE while a request is accepted: ignored, request proceeds
        tbl[7]  = mk(4'b0010, 8'h3C, 8'hFF, 8'd0, 1, 4'b0010, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        tbl[8]  = mk(4'b0000, 8'h3C, 8'hFF, 8'd0, 0, 4'b0000, 8'h3C, 8'h3C, 8'h00, 4'b0000, 4'b0010, 1);
        tbl[9]  = mk(4'b0000, 8'h3C, 8'hFF, 8'd0, 0, 4'b0000, 8'h00, 8'h00, 8'h3C, 4'b0010, 4'b0010, 1);
        tbl[10] = mk(4'b0000, 8'h3C, 8'hFF, 8'd0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        // rr pointer at 2: requester 2 beats 0; requester 0 stays pending while busy
        tbl[11] = mk(4'b0101, 8'hFF, 8'hA5, 8'd1, 0, 4'b0100, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        tbl[12] = mk(4'b0101, 8'h11, 8'h22, 8'd9, 0, 4'b0000, 8'hFF, 8'hA5, 8'h00, 4'b0000, 4'b0100, 1);
        tbl[13] = mk(4'b0101, 8'h11, 8'h22, 8'd9, 0, 4'b0000, 8'hFF, 8'hA5, 8'h00, 4'b0000, 4'b0100, 1);
        tbl[14] = mk(4'b0101, 8'h11, 8'h22, 8'd9, 0, 4'b0000, 8'h00, 8'h00, 8'hFF, 4'b0100, 4'b0100, 1);
        // zero mask on requester 2, hold 2: three silent FORCE cycles, done still pulses
        tbl[15] = mk(4'b0100, 8'h00, 8'hFF, 8'd2, 0, 4'b0100, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);
        tbl[16] = mk(4'b0000, 8'h00, 8'hFF, 8'd2, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0100, 1);
        tbl[17] = mk(4'b0000, 8'h00, 8'hFF, 8'd2, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0100, 1);
        tbl[18] = mk(4'b0000, 8'h00, 8'hFF, 8'd2, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0100, 1);
        tbl[19] = mk(4'b0000, 8'h00, 8'hFF, 8'd2, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0100, 4'b0100, 1);
        tbl[20] = mk(4'b0000, 8'h00, 8'hFF, 8'd2, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0);

        exp_own[0] = 4'b0001; exp_own[1] = 4'b0010; exp_own[2] = 4'b0100;
        exp_own[3] = 4'b1000; exp_own[4] = 4'b0001;

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        abort     = 1'b0;
        set_all(8'hFF, 8'hFF, 8'd0);
`ifdef FORCE_RELEASE_SCHED_ERR_EN
        err_clr   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_force_en", force_en, 8'h00);
        chk("rst_force_val", force_val, 8'h00);
        chk("rst_release", release_p, 8'h00);
        chk("rst_done", done, 4'b0000);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            set_all(tbl[i].mask, tbl[i].value, tbl[i].hold);
            abort = tbl[i].abrt;
            #1;
            chk($sformatf("v%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("v%0d_force_en", i), force_en, tbl[i].fen);
            chk($sformatf("v%0d_force_val", i), force_val, tbl[i].fval);
            chk($sformatf("v%0d_release", i), release_p, tbl[i].rel);
            chk($sformatf("v%0d_done", i), done, tbl[i].dn);
            chk($sformatf("v%0d_grant", i), grant, tbl[i].gnt);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
        end
        abort = 1'b0;

        // ---------------- round robin, all requesting, hold 0 ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        set_all(8'hFF, 8'h11, 8'd0);
        ngr = 0; gap = 0; prev_g = 4'b0000;
        for (int c = 0; c < 200 && ngr < 5; c++) begin
            @(negedge clk); #1;
            if (grant !== 4'b0000 && prev_g === 4'b0000) begin
                chk($sformatf("rr_owner%0d", ngr), grant, exp_own[ngr]);
                if (ngr > 0) chk($sformatf("rr_gap%0d", ngr), gap, 1);
                gap = 0;
                ngr++;
            end else if (busy === 1'b0) begin
                gap++;
            end
            prev_g = grant;
        end
        chk("rr_grants", ngr, 5);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);

        // ---------------- abort mid-FORCE (rr pointer now at 1 -> requester 3 wins) ----------------
        req_valid = 4'b1000;
        set_all(8'hAA, 8'h0F, 8'd200);
        wait_busy(ok);
        chk("abort_started", ok, 1'b1);
        req_valid = 4'b0000;
        chk("abort_grant", grant, 4'b1000);
        repeat (4) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_still_forcing", force_en, 8'h0A & 8'hAA | 8'hA0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_release", release_p, 8'hAA);
        chk("abort_done", done, 4'b1000);
        chk("abort_force_off", force_en, 8'h00);
        @(negedge clk); #1;
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_release", release_p, 8'h00);

        // abort in IDLE: no state change
        abort = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_abort_busy", busy, 1'b0);
            chk("idle_abort_grant", grant, 4'b0000);
        end
        abort = 1'b0;

        // ---------------- max hold (requester 0) ----------------
        req_valid = 4'b0001;
        set_all(8'h81, 8'h01, 8'hFF);
        wait_busy(ok);
        chk("maxhold_started", ok, 1'b1);
        req_valid = 4'b0000;
        n = 0;
        while (force_en === 8'h81 && n < 400) begin
            n++;
            @(negedge clk); #1;
        end
        chk("maxhold_cycles", n, 256);
        chk("maxhold_release", release_p, 8'h81);
        chk("maxhold_done", done, 4'b0001);
        repeat (2) @(negedge clk);

        // ---------------- reset mid-FORCE ----------------
        req_valid = 4'b0100;
        set_all(8'hF0, 8'hF0, 8'd50);
        wait_busy(ok);
        chk("rstmid_started", ok, 1'b1);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_force_en", force_en, 8'h00);
        chk("rstmid_grant", grant, 4'b0000);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_release", release_p, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        set_all(8'h01, 8'h01, 8'd0);
        rel_seen = 0;
        for (int c = 0; c < 10 && grant === 4'b0000; c++) begin
            @(negedge clk); #1;
            if (release_p !== 8'h00) rel_seen++;
        end
        chk("rstmid_no_release", rel_seen, 0);
        chk("rstmid_restart_owner", grant, 4'b0001);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);

`ifdef FORCE_RELEASE_SCHED_ERR_EN
        // ---------------- sticky error flag ----------------
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("err_idle_abort", err, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clr", err, 1'b0);
        req_valid = 4'b0010;
        set_all(8'h00, 8'hFF, 8'd0);
        wait_busy(ok);
        req_valid = 4'b0000;
        chk("err_zero_mask", err, 1'b1);
        repeat (4) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
